// File: rtl/addsub_burst_accumulator.sv
// addsub_burst_accumulator: sums a burst of LEN operands into an N-bit accumulator.
// Each operand is added or subtracted. The final sum, the last carry-out and a sticky
// signed-overflow flag are held until the consumer takes them over a valid/ready handshake.

// Combinational n-bit adder/subtracter: cin=0 gives x+y, cin=1 gives x-y (x + ~y + 1).
module Adder_subtracter_nBit #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N-1:0] y_eff_s;
  logic [N:0]   sum_s;

  // Invert y for subtraction and fold cin in as the +1 of the two's complement.
  always_comb begin
    y_eff_s = y ^ {N{cin}};
    sum_s   = {1'b0, x} + {1'b0, y_eff_s} + {{N{1'b0}}, cin};
    s       = sum_s[N-1:0];
    cout    = sum_s[N];
  end

endmodule

module addsub_burst_accumulator #(
  parameter int N     = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Two's complement overflow: both operands have the same sign and the sum's sign differs.
  function automatic logic signed_ovf_f(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [N-1:0]     add_s_s;
  logic             add_cout_s;
  logic [N-1:0]     y_eff_s;
  logic             xfer_s;

  Adder_subtracter_nBit #(.N(N)) u_addsub (
    .x    (acc_q),
    .y    (in_data),
    .cin  (in_sub),
    .s    (add_s_s),
    .cout (add_cout_s)
  );

  // Decode handshake strobes and the effective second operand used by the overflow test.
  always_comb begin
    y_eff_s = in_data ^ {N{in_sub}};
    xfer_s  = (state_q == ST_ACCUM) && in_valid;
  end

  // Next-state logic. Every register holds its value unless the current state updates it.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = {N{1'b0}};
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          cnt_d   = len;
          if (len != {LEN_W{1'b0}}) begin
            state_d = ST_ACCUM;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        // start is deliberately not looked at here, so a stray start cannot restart the burst.
        if (xfer_s) begin
          acc_d   = add_s_s;
          carry_d = add_cout_s;
          ovf_d   = ovf_q | signed_ovf_f(acc_q[N-1], y_eff_s[N-1], add_s_s[N-1]);
          cnt_d   = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset wins over any start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= {N{1'b0}};
      cnt_q   <= {LEN_W{1'b0}};
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs decode straight from the state flops; the result is forced to 0 outside DONE.
  always_comb begin
    in_ready  = (state_q == ST_ACCUM);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    if (state_q == ST_DONE) begin
      out_sum   = acc_q;
      out_carry = carry_q;
      out_ovf   = ovf_q;
    end else begin
      out_sum   = {N{1'b0}};
      out_carry = 1'b0;
      out_ovf   = 1'b0;
    end
  end

endmodule

// File: tb/tb_addsub_burst_accumulator.sv
// Scoreboard bench for addsub_burst_accumulator. Each burst pushes its hand-computed
// {sum, carry, ovf}; a negedge monitor pops and compares on every output handshake.
module tb_addsub_burst_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_carry;
  logic       out_ovf;
  logic       busy;

  int tests  = 0;
  int failed = 0;

  logic [9:0] exp_q [$];
  logic [7:0] op_d [0:3];
  logic       op_s [0:3];

  addsub_burst_accumulator #(.N(8), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carry(out_carry), .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the presented result against the scoreboard on each handshake.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {22'd0, out_sum, out_carry, out_ovf}, 32'hFFFF_FFFF);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("result_sum", {24'd0, out_sum}, {24'd0, e[9:2]});
        check("result_carry", {31'd0, out_carry}, {31'd0, e[1]});
        check("result_ovf", {31'd0, out_ovf}, {31'd0, e[0]});
      end
    end
  end

  // Start a burst of n operands from op_d/op_s, stream them back-to-back, then take the result
  // after 'stall' cycles of out_ready=0, checking stability during the stall.
  task automatic run_burst(input int n, input int stall, input logic [7:0] exp_sum);
    start = 1'b1;
    len   = 4'(n);
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = op_d[i];
      in_sub   = op_s[i];
      check("in_ready_accum", {31'd0, in_ready}, 32'd1);
      check("no_early_valid", {31'd0, out_valid}, 32'd0);
      tick();
    end
    in_valid = 1'b0;
    check("latency_out_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_sum", {24'd0, out_sum}, {24'd0, exp_sum});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_hs_valid", {31'd0, out_valid}, 32'd0);
    check("post_hs_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = 4'd0; in_valid = 1'b1;
    in_data = 8'd0; in_sub = 1'b0; out_ready = 1'b0;

    // 1. Reset for 2 cycles with in_valid high.
    tick(); tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum", {24'd0, out_sum}, 32'd0);
    check("rst_flags", {30'd0, out_carry, out_ovf}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;

    // 2. Add burst: 10+20+30 = 60, no carry, no overflow.
    op_d[0] = 8'd10; op_s[0] = 1'b0;
    op_d[1] = 8'd20; op_s[1] = 1'b0;
    op_d[2] = 8'd30; op_s[2] = 1'b0;
    exp_q.push_back({8'd60, 1'b0, 1'b0});
    run_burst(3, 0, 8'd60);

    // 3. 5 - 7 wraps to 0xFE with a borrow; stall the consumer for 4 cycles.
    op_d[0] = 8'd5; op_s[0] = 1'b0;
    op_d[1] = 8'd7; op_s[1] = 1'b1;
    exp_q.push_back({8'hFE, 1'b0, 1'b0});
    run_burst(2, 4, 8'hFE);

    // 4. 100+100 overflows (sticky), then -100 gives 100 with carry out.
    op_d[0] = 8'd100; op_s[0] = 1'b0;
    op_d[1] = 8'd100; op_s[1] = 1'b0;
    op_d[2] = 8'd100; op_s[2] = 1'b1;
    exp_q.push_back({8'd100, 1'b1, 1'b1});
    run_burst(3, 0, 8'd100);

    // 5a. len=0 goes straight to DONE with a zero result; in_valid is not consumed.
    exp_q.push_back({8'd0, 1'b0, 1'b0});
    start = 1'b1; len = 4'd0;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 8'd55;
    check("len0_valid", {31'd0, out_valid}, 32'd1);
    check("len0_busy", {31'd0, busy}, 32'd1);
    check("len0_in_ready", {31'd0, in_ready}, 32'd0);
    // start during the DONE handshake must not launch a burst.
    start = 1'b1; len = 4'd3; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    check("done_start_ignored", {31'd0, busy}, 32'd0);

    // 5b. start during ACCUM is ignored and an in_valid gap stalls the count: 3+4 = 7.
    exp_q.push_back({8'd7, 1'b0, 1'b0});
    start = 1'b1; len = 4'd2;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 8'd3; in_sub = 1'b0;
    tick();
    in_valid = 1'b0; start = 1'b1; len = 4'd5;
    tick(); tick();
    start = 1'b0;
    check("gap_in_ready", {31'd0, in_ready}, 32'd1);
    check("gap_no_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1; in_data = 8'd4;
    tick();
    in_valid = 1'b0;
    check("gap_latency", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // 6. Reset mid-burst discards the partial result; a new len=1 burst of +7 gives 7.
    start = 1'b1; len = 4'd3;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 8'd50;
    tick();
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_sum", {24'd0, out_sum}, 32'd0);
    check("midrst_acc", {24'd0, dut.acc_q}, 32'd0);
    rst_n = 1'b1;
    op_d[0] = 8'd7; op_s[0] = 1'b0;
    exp_q.push_back({8'd7, 1'b0, 1'b0});
    run_burst(1, 0, 8'd7);

    tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
